// File: rtl/tow_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tow_game_ctrl
//  Description : Tug-of-war game sequencer. Runs IDLE -> COUNTDOWN -> PLAY ->
//                WIN_L/WIN_R, moves a one-hot rope LED on player presses and
//                blinks the winning end LED on each slow tick.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_LEDS    rope positions (odd, >= 3); centre index is N_LEDS/2
//    CD_TICKS  slowen ticks spent in COUNTDOWN before PLAY (>= 1)
//  Ports
//    clk       in   system clock
//    rst       in   asynchronous active-high reset
//    slowen    in   one-cycle slow tick
//    btn_l     in   left player button level (debounced, synchronous)
//    btn_r     in   right player button level (debounced, synchronous)
//    clr       in   one-cycle request: recentre and start a new countdown
//    leds      out  one-hot rope position, index 0 = left end
//    winner_l  out  high while left player has won
//    winner_r  out  high while right player has won
//    playing   out  high while in PLAY
//  Configuration macro
//    TOW_FALSE_START_EN  when defined, a single-sided press during COUNTDOWN
//                        hands the win to the opposite player.
// ============================================================================
module tow_game_ctrl #(
   parameter int N_LEDS   = 7,
   parameter int CD_TICKS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              slowen,
   input  logic              btn_l,
   input  logic              btn_r,
   input  logic              clr,
   output logic [N_LEDS-1:0] leds,
   output logic              winner_l,
   output logic              winner_r,
   output logic              playing
);

   localparam int PW = $clog2(N_LEDS);
   localparam int CW = $clog2(CD_TICKS + 1);

   localparam logic [PW-1:0]     c_CTR     = PW'(N_LEDS / 2);
   localparam logic [PW-1:0]     c_LAST    = PW'(N_LEDS - 1);
   localparam logic [CW-1:0]     c_CD_LOAD = CW'(CD_TICKS);
   localparam logic [N_LEDS-1:0] c_ONE     = N_LEDS'(1);
   localparam logic [N_LEDS-1:0] c_CTR_LED = c_ONE << c_CTR;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_PLAY      = 3'd2,
      S_WIN_L     = 3'd3,
      S_WIN_R     = 3'd4
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [PW-1:0]     r_pos, w_pos_nxt;
   logic [CW-1:0]     r_cd_cnt, w_cd_nxt;
   logic              r_blink, w_blink_nxt;
   logic              r_btn_l_q, r_btn_r_q;
   logic [N_LEDS-1:0] r_leds, w_leds_nxt;
   logic              r_winner_l, r_winner_r, r_playing;

   logic w_press_l, w_press_r;
   logic w_fs_l, w_fs_r;

   assign w_press_l = btn_l & ~r_btn_l_q;
   assign w_press_r = btn_r & ~r_btn_r_q;

`ifdef TOW_FALSE_START_EN
   // A lone press during countdown is a false start; a simultaneous pair cancels.
   assign w_fs_l = w_press_l & ~w_press_r;
   assign w_fs_r = w_press_r & ~w_press_l;
`else
   assign w_fs_l = 1'b0;
   assign w_fs_r = 1'b0;
`endif

   // State / datapath registers. Outputs are registered from next-state values
   // so they track the state on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pos      <= c_CTR;
         r_cd_cnt   <= '0;
         r_blink    <= 1'b0;
         r_btn_l_q  <= 1'b0;
         r_btn_r_q  <= 1'b0;
         r_leds     <= c_CTR_LED;
         r_winner_l <= 1'b0;
         r_winner_r <= 1'b0;
         r_playing  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pos      <= w_pos_nxt;
         r_cd_cnt   <= w_cd_nxt;
         r_blink    <= w_blink_nxt;
         r_btn_l_q  <= btn_l;
         r_btn_r_q  <= btn_r;
         r_leds     <= w_leds_nxt;
         r_winner_l <= (w_state_nxt == S_WIN_L);
         r_winner_r <= (w_state_nxt == S_WIN_R);
         r_playing  <= (w_state_nxt == S_PLAY);
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
      w_cd_nxt    = r_cd_cnt;
      w_blink_nxt = r_blink;

      if (clr) begin
         w_state_nxt = S_COUNTDOWN;
         w_pos_nxt   = c_CTR;
         w_cd_nxt    = c_CD_LOAD;
         w_blink_nxt = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
            end
            S_COUNTDOWN: begin
               if (w_fs_l) begin
                  w_state_nxt = S_WIN_R;
                  w_blink_nxt = 1'b1;
               end else if (w_fs_r) begin
                  w_state_nxt = S_WIN_L;
                  w_blink_nxt = 1'b1;
               end else if (slowen) begin
                  w_cd_nxt = r_cd_cnt - CW'(1);
                  if (r_cd_cnt == CW'(1)) begin
                     w_state_nxt = S_PLAY;
                  end
               end
            end
            S_PLAY: begin
               if (w_press_l && !w_press_r) begin
                  w_pos_nxt = r_pos - PW'(1);
                  if (r_pos == PW'(1)) begin
                     w_state_nxt = S_WIN_L;
                     w_blink_nxt = 1'b1;
                  end
               end else if (w_press_r && !w_press_l) begin
                  w_pos_nxt = r_pos + PW'(1);
                  if (r_pos == c_LAST - PW'(1)) begin
                     w_state_nxt = S_WIN_R;
                     w_blink_nxt = 1'b1;
                  end
               end
            end
            S_WIN_L, S_WIN_R: begin
               if (slowen) begin
                  w_blink_nxt = ~r_blink;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // LED pattern for the upcoming state
   always_comb begin
      w_leds_nxt = c_CTR_LED;
      case (w_state_nxt)
         S_PLAY:  w_leds_nxt = c_ONE << w_pos_nxt;
         S_WIN_L: w_leds_nxt = w_blink_nxt ? c_ONE : '0;
         S_WIN_R: w_leds_nxt = w_blink_nxt ? (c_ONE << c_LAST) : '0;
         default: w_leds_nxt = c_CTR_LED;
      endcase
   end

   assign leds     = r_leds;
   assign winner_l = r_winner_l;
   assign winner_r = r_winner_r;
   assign playing  = r_playing;

endmodule
`default_nettype wire
